// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one fixed-latency memory port between the
// pipeline MEM stage (CPU, fixed priority) and a DMA/loader master. Each access
// holds the port for MEM_LAT cycles, then acks the owner for one cycle.
// A starvation counter forces the DMA through after STARVE_LIMIT consecutive
// CPU grants made while the DMA was waiting.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              cpu_stall_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              dma_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              owner_q, owner_d;        // 1 = DMA owns the port
    logic              grant_cpu, grant_dma;
    logic              mem_en_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              cpu_ack_d, dma_ack_d;
    logic [DATA_W-1:0] cpu_rdata_d, dma_rdata_d;

    // Stall is forced low while reset is asserted so the pipeline never sees a
    // stall from a request that the arbiter cannot yet service.
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_o & rst_i;

    // State register and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            starve_q    <= '0;
            owner_q     <= 1'b0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            cpu_ack_o   <= 1'b0;
            dma_ack_o   <= 1'b0;
            cpu_rdata_o <= '0;
            dma_rdata_o <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            mem_en_o    <= mem_en_d;
            mem_we_o    <= mem_we_d;
            mem_addr_o  <= mem_addr_d;
            mem_wdata_o <= mem_wdata_d;
            cpu_ack_o   <= cpu_ack_d;
            dma_ack_o   <= dma_ack_d;
            cpu_rdata_o <= cpu_rdata_d;
            dma_rdata_o <= dma_rdata_d;
        end
    end

    // Arbitration, access sequencing and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        owner_d     = owner_q;
        grant_cpu   = 1'b0;
        grant_dma   = 1'b0;
        mem_en_d    = mem_en_o;
        mem_we_d    = mem_we_o;
        mem_addr_d  = mem_addr_o;
        mem_wdata_d = mem_wdata_o;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_o;
        dma_rdata_d = dma_rdata_o;

        unique case (state_q)
            IDLE: begin
                if (dma_req_i && (starve_q == CNT_W'(STARVE_LIMIT))) begin
                    grant_dma = 1'b1;
                end else if (cpu_req_i) begin
                    grant_cpu = 1'b1;
                end else if (dma_req_i) begin
                    grant_dma = 1'b1;
                end

                if (grant_cpu) begin
                    owner_d     = 1'b0;
                    mem_we_d    = cpu_we_i;
                    mem_addr_d  = cpu_addr_i;
                    mem_wdata_d = cpu_wdata_i;
                    if (!dma_req_i) begin
                        starve_d = '0;
                    end else if (starve_q != CNT_W'(STARVE_LIMIT)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end

                if (grant_dma) begin
                    owner_d     = 1'b1;
                    mem_we_d    = dma_we_i;
                    mem_addr_d  = dma_addr_i;
                    mem_wdata_d = dma_wdata_i;
                    starve_d    = '0;
                end

                if (grant_cpu || grant_dma) begin
                    state_d  = BUSY;
                    lat_d    = '0;
                    mem_en_d = 1'b1;
                end
            end

            BUSY: begin
                if (lat_q == LAT_W'(MEM_LAT - 1)) begin
                    // mem_we_o still carries the latched write flag here; a
                    // write leaves the owner's read data untouched.
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (owner_q) begin
                        dma_ack_d = 1'b1;
                        if (!mem_we_o) dma_rdata_d = mem_rdata_i;
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (!mem_we_o) cpu_rdata_d = mem_rdata_i;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
